// File: rtl/rr_serializer_pkg.sv
// Shared types and helpers for the wide-record FIFO serializer.
package rr_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } ser_state_t;

    localparam int STAT_WIDTH = 32;

    // Number of output beats needed to carry one entry: ceil(in_w / out_w).
    function automatic int nbeats(input int in_w, input int out_w);
        return (in_w - 1) / out_w + 1;
    endfunction

endpackage

// File: rtl/rr_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones, cleared by rst_n.
module rr_sat_counter
    import rr_serializer_pkg::*;
#(
    parameter int WIDTH = STAT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Advance on inc unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rr_fifo_serializer.sv
// rr_fifo_serializer: pops one IN_WIDTH-bit entry from the wide record FIFO (1-cycle read
// latency) and emits it LSB-first as NBEATS OUT_WIDTH-bit beats on a valid/ready stream.
// Optional statistics counters are enabled by defining RR_SERIALIZER_STATS_EN.
module rr_fifo_serializer
    import rr_serializer_pkg::*;
#(
    parameter  int IN_WIDTH  = 600,
    parameter  int OUT_WIDTH = 512,
    localparam int NBEATS    = nbeats(IN_WIDTH, OUT_WIDTH),
    localparam int BEAT_W    = $clog2(NBEATS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_WIDTH-1:0]   fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [BEAT_W-1:0]     out_beat
`ifdef RR_SERIALIZER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_entries,
    output logic [STAT_WIDTH-1:0] stat_stall
`endif
);

    localparam int                BUF_W     = NBEATS * OUT_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    ser_state_t        state_q, state_d;
    logic [BEAT_W-1:0] beat_q,  beat_d;
    logic [BUF_W-1:0]  buf_q,   buf_d;
    logic              rd_en_c;
    logic              last_c;

    // Next-state, beat index, hold buffer capture and pop request
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        buf_d   = buf_q;
        rd_en_c = 1'b0;
        last_c  = (beat_q == LAST_BEAT);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en_c = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Read data arrives one cycle after the pop; upper pad bits become zero.
                buf_d   = BUF_W'(fifo_dout);
                beat_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (last_c) begin
                        // Chain straight into the next pop to keep only one bubble per entry.
                        if (!fifo_empty) begin
                            rd_en_c = 1'b1;
                            state_d = WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stream outputs: present the current beat slice only while sending
    always_comb begin
        out_valid = (state_q == SEND);
        out_last  = out_valid && last_c;
        out_beat  = out_valid ? beat_q : '0;
        out_data  = '0;
        if (out_valid) begin
            for (int i = 0; i < NBEATS; i++) begin
                if (beat_q == BEAT_W'(i)) begin
                    out_data = buf_q[i*OUT_WIDTH +: OUT_WIDTH];
                end
            end
        end
    end

    assign fifo_rd_en = rst_n && rd_en_c;

    // State, beat index and hold buffer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            buf_q   <= buf_d;
        end
    end

`ifdef RR_SERIALIZER_STATS_EN
    logic entry_done;
    logic stall_cycle;

    assign entry_done  = out_valid && out_ready && out_last;
    assign stall_cycle = out_valid && !out_ready;

    rr_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_entries (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (entry_done),
        .count (stat_entries)
    );

    rr_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_cycle),
        .count (stat_stall)
    );
`endif

endmodule

// File: tb/tb_rr_fifo_serializer.sv
// Bench for rr_fifo_serializer: a 600->512 instance and a 512->512 instance, each fed by a
// queue-based FIFO model with 1-cycle read latency and checked against expected beat lists.
module tb_rr_fifo_serializer;

    localparam int IN_W  = 600;
    localparam int OUT_W = 512;
    localparam int NB    = 2;
    localparam int BW    = 2;
    localparam int IN6   = 512;
    localparam int BW6   = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [IN_W-1:0]   fifo_dout;
    logic              fifo_empty, fifo_rd_en;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid, out_ready, out_last;
    logic [BW-1:0]     out_beat;
    logic [IN6-1:0]    fifo_dout6;
    logic              fifo_empty6, fifo_rd_en6;
    logic [IN6-1:0]    out_data6;
    logic              out_valid6, out_ready6, out_last6;
    logic [BW6-1:0]    out_beat6;
`ifdef RR_SERIALIZER_STATS_EN
    logic [31:0] stat_entries, stat_stall, stat_entries6, stat_stall6;
`endif

    rr_fifo_serializer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_beat(out_beat)
`ifdef RR_SERIALIZER_STATS_EN
        , .stat_entries(stat_entries), .stat_stall(stat_stall)
`endif
    );

    rr_fifo_serializer #(.IN_WIDTH(IN6), .OUT_WIDTH(OUT_W)) dut6 (
        .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout6), .fifo_empty(fifo_empty6),
        .fifo_rd_en(fifo_rd_en6), .out_data(out_data6), .out_valid(out_valid6),
        .out_ready(out_ready6), .out_last(out_last6), .out_beat(out_beat6)
`ifdef RR_SERIALIZER_STATS_EN
        , .stat_entries(stat_entries6), .stat_stall(stat_stall6)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             last;
        logic [BW-1:0]    beat;
    } beat_t;

    typedef struct {
        logic       rdy;
        logic       rd;
        logic       v;
        logic       last;
        logic [1:0] beat;
        int         sel;
    } vec_t;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               stall_cnt = 0;
    int               ent_cnt = 0;
    logic [IN_W-1:0]  fq[$];
    beat_t            exp_q[$];
    logic [IN6-1:0]   fq6[$];
    logic [IN6-1:0]   exp6[$];
    logic             hold_pending = 1'b0;
    logic [OUT_W-1:0] prev_data;
    logic             prev_last;
    logic [BW-1:0]    prev_beat;

    function automatic void chk(input string nm, input logic [639:0] got, input logic [639:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    function automatic void fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got unexpected event expected none", nm);
    endfunction

    function automatic logic [IN_W-1:0] rand_entry();
        logic [IN_W-1:0] r;
        r = '0;
        repeat (19) r = (r << 32) | IN_W'($urandom);
        return r;
    endfunction

    // Model FIFO push plus the beats the stream must carry for this entry.
    task automatic push_entry(input logic [IN_W-1:0] e);
        logic [NB*OUT_W-1:0] ext;
        beat_t b;
        fq.push_back(e);
        ext = (NB*OUT_W)'(e);
        for (int k = 0; k < NB; k++) begin
            b.d    = ext[k*OUT_W +: OUT_W];
            b.last = (k == NB - 1);
            b.beat = BW'(k);
            exp_q.push_back(b);
        end
    endtask

    task automatic push_entry6(input logic [IN6-1:0] e);
        fq6.push_back(e);
        exp6.push_back(e);
    endtask

    // Stream-rule and scoreboard checks, run once per cycle after inputs settle.
    task automatic monitor();
        beat_t b;
        logic [IN6-1:0] e6;
        if (fifo_rd_en) begin
            chk("rd_en_while_empty", fifo_empty, 1'b0);
            chk("rd_en_mid_entry", out_valid && !(out_ready && out_last), 1'b0);
        end
        if (rst_n && hold_pending) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, prev_data);
            chk("hold_last", out_last, prev_last);
            chk("hold_beat", out_beat, prev_beat);
        end
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("extra_beat");
            end else begin
                b = exp_q.pop_front();
                chk("beat_data", out_data, b.d);
                chk("beat_last", out_last, b.last);
                chk("beat_idx", out_beat, b.beat);
            end
            if (out_last) ent_cnt++;
        end
        if (rst_n && out_valid && !out_ready) stall_cnt++;
        hold_pending = rst_n && out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
        prev_beat = out_beat;
        if (fifo_rd_en6) chk("rd_en6_while_empty", fifo_empty6, 1'b0);
        if (rst_n && out_valid6) begin
            chk("t6_last", out_last6, 1'b1);
            chk("t6_beat", out_beat6, 1'b0);
            if (out_ready6) begin
                if (exp6.size() == 0) begin
                    fail_now("extra_beat6");
                end else begin
                    e6 = exp6.pop_front();
                    chk("t6_data", out_data6, e6);
                end
            end
        end
    endtask

    task automatic drive_sample(input logic rdy, input logic rdy6);
        @(negedge clk);
        out_ready   = rdy;
        out_ready6  = rdy6;
        fifo_empty  = (fq.size() == 0);
        fifo_empty6 = (fq6.size() == 0);
        #1;
        monitor();
    endtask

    // Clock edge: the model FIFO presents popped data the cycle after fifo_rd_en.
    task automatic advance();
        logic p, p6, in_rst;
        logic [IN_W-1:0] r;
        p = fifo_rd_en;
        p6 = fifo_rd_en6;
        in_rst = !rst_n;
        @(posedge clk);
        #1;
        if (in_rst) begin
            fq.delete(); exp_q.delete(); fq6.delete(); exp6.delete();
            hold_pending = 1'b0;
            stall_cnt = 0;
            ent_cnt = 0;
        end
        r = rand_entry();
        if (p && fq.size() > 0) fifo_dout = fq.pop_front();
        else fifo_dout = r;
        if (p6 && fq6.size() > 0) fifo_dout6 = fq6.pop_front();
        else fifo_dout6 = r[IN6-1:0];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t1[5];
        vec_t t2[14];
        logic [IN_W-1:0]  e1, tmp;
        logic [OUT_W-1:0] hi;
        logic found;
        int pushed;

        // Vector tables: single entry timing, and four back-to-back entries.
        t1[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, -1};
        t1[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, -1};
        t1[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0,  0};
        t1[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1,  1};
        t1[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, -1};
        for (int c = 0; c < 14; c++) begin
            t2[c].rdy  = 1'b1;
            t2[c].rd   = (c % 3 == 0) && (c <= 9);
            t2[c].v    = (c >= 2) && (c <= 12) && ((c - 2) % 3 != 2);
            t2[c].beat = t2[c].v ? 2'((c - 2) % 3) : 2'd0;
            t2[c].last = t2[c].v && (t2[c].beat == 2'd1);
            t2[c].sel  = -1;
        end

        rst_n = 1'b0;
        out_ready = 1'b0; out_ready6 = 1'b0;
        fifo_empty = 1'b1; fifo_empty6 = 1'b1;
        tmp = rand_entry();
        fifo_dout = tmp;
        fifo_dout6 = tmp[IN6-1:0];

        // Reset: pop strobe held low even with a non-empty FIFO, outputs cleared
        push_entry(rand_entry());
        drive_sample(1'b1, 1'b1);
        chk("rst_rd_en_forced", fifo_rd_en, 1'b0);
        advance();
        push_entry(rand_entry());
        drive_sample(1'b1, 1'b1);
        chk("rst_rd_en_forced2", fifo_rd_en, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_beat", out_beat, 2'd0);
        chk("rst_data", out_data, '0);
        advance();
        rst_n = 1'b1;

        // Empty FIFO forever: nothing popped, nothing sent
        for (int c = 0; c < 20; c++) begin
            drive_sample(1'($urandom_range(0, 1)), 1'b1);
            chk("t4_rd_en", fifo_rd_en, 1'b0);
            chk("t4_valid", out_valid, 1'b0);
            advance();
        end

        // Single entry with full-width padding check
        e1 = rand_entry();
        e1[IN_W-1] = 1'b1;
        e1[11:0] = 12'hABC;
        hi = {424'b0, e1[599:512]};
        push_entry(e1);
        for (int c = 0; c < 5; c++) begin
            drive_sample(t1[c].rdy, 1'b1);
            chk("t1_rd_en", fifo_rd_en, t1[c].rd);
            chk("t1_valid", out_valid, t1[c].v);
            chk("t1_last", out_last, t1[c].last);
            chk("t1_beat", out_beat, t1[c].beat);
            if (t1[c].sel == 0) chk("t1_beat0_data", out_data, e1[511:0]);
            if (t1[c].sel == 1) chk("t1_beat1_data", out_data, hi);
            advance();
        end

        // Four preloaded entries, ready held high
        for (int k = 0; k < 4; k++) push_entry(rand_entry());
        for (int c = 0; c < 14; c++) begin
            drive_sample(t2[c].rdy, 1'b1);
            chk("t2_rd_en", fifo_rd_en, t2[c].rd);
            chk("t2_valid", out_valid, t2[c].v);
            chk("t2_last", out_last, t2[c].last);
            chk("t2_beat", out_beat, t2[c].beat);
            advance();
        end
        chk("t2_all_beats", exp_q.size(), 0);

        // Random arrivals with ~30% ready duty
        pushed = 0;
        for (int c = 0; c < 4000; c++) begin
            if (pushed < 20 && $urandom_range(0, 3) == 0) begin
                push_entry(rand_entry());
                pushed++;
            end
            drive_sample(1'($urandom_range(0, 9) < 3), 1'b1);
            advance();
            if (pushed == 20 && exp_q.size() == 0 && fq.size() == 0) break;
        end
        chk("t3_drained", exp_q.size(), 0);
        chk("t3_pushed", pushed, 20);
`ifdef RR_SERIALIZER_STATS_EN
        chk("stat_stall", stat_stall, stall_cnt);
        chk("stat_entries", stat_entries, ent_cnt);
`endif

        // Equal widths: one beat per entry, two cycles per entry
        for (int k = 0; k < 3; k++) begin
            tmp = rand_entry();
            push_entry6(tmp[IN6-1:0]);
        end
        for (int c = 0; c < 8; c++) begin
            drive_sample(1'b1, 1'b1);
            chk("t6_rd_en", fifo_rd_en6, (c % 2 == 0) && (c <= 4));
            chk("t6_valid", out_valid6, (c >= 2) && (c % 2 == 0) && (c <= 6));
            advance();
        end
        chk("t6_all_beats", exp6.size(), 0);

        // Reset during beat 0 of an entry, then a fresh entry
        push_entry(rand_entry());
        push_entry(rand_entry());
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            drive_sample(1'b0, 1'b1);
            if (out_valid) found = 1'b1;
            else advance();
        end
        chk("t5_reach_beat0", {out_valid, out_beat}, {1'b1, 2'd0});
        rst_n = 1'b0;
        #1;
        chk("t5_rd_en_in_reset", fifo_rd_en, 1'b0);
        advance();
        rst_n = 1'b1;
        drive_sample(1'b1, 1'b1);
        chk("t5_valid", out_valid, 1'b0);
        chk("t5_data", out_data, '0);
        chk("t5_last", out_last, 1'b0);
        chk("t5_beat", out_beat, 2'd0);
        chk("t5_rd_en", fifo_rd_en, 1'b0);
        advance();
        push_entry(rand_entry());
        for (int c = 0; c < 20; c++) begin
            drive_sample(1'b1, 1'b1);
            advance();
            if (exp_q.size() == 0 && fq.size() == 0) break;
        end
        chk("t5_after_reset", exp_q.size(), 0);
`ifdef RR_SERIALIZER_STATS_EN
        chk("stat_entries_after_rst", stat_entries, ent_cnt);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
